// File: rtl/sdram_cmd_responder.sv
// sdram_cmd_responder: SDRAM device emulator that decodes the command bus, backs bursts with RAM and flags protocol errors
module sdram_cmd_responder #(
  parameter int BANK_BITS = 2,
  parameter int ROW_BITS  = 4,
  parameter int COL_BITS  = 8,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CKE,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [2:0]  BA,
  input  logic [12:0] A,
  input  logic        DQML,
  input  logic        DQMH,
  input  logic [15:0] DQ_in,
  output logic [15:0] DQ_out,
  output logic        DQ_oe,
  output logic        ready,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam int NB = 1 << BANK_BITS;
  localparam int AW = BANK_BITS + ROW_BITS + COL_BITS;
  localparam int TW = 8;
  typedef enum logic [1:0] {IDLE, WBURST, RBURST} st_t;
  st_t state_q, state_d;
  logic ready_q, ready_d, cl2_q, cl2_d, full_q, full_d, err_q, err_d;
  logic [2:0] bl_q, bl_d, code_q, code_d, cnt_q, cnt_d, code;
  logic [NB-1:0] open_q, open_d;
  logic [NB-1:0][ROW_BITS-1:0] row_q, row_d;
  logic [NB-1:0][TW-1:0] trcd_q, trcd_d;
  logic [TW-1:0] trp_q, trp_d, trfc_q, trfc_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [BANK_BITS-1:0] bb_q, bb_d, bank;
  logic [ROW_BITS-1:0] rb_q, rb_d;
  logic bfull_q, bfull_d;
  logic [2:0] v_q, v_d;
  logic [1:0][15:0] d_q, d_d;
  logic [1:0] m_q, m_d;
  logic oe_q, oe_d, sel_v, we, re;
  logic [15:0] out_q, out_d, sel_d, rd_q;
  logic [AW-1:0] addr;
  logic [15:0] mem [0:(1<<AW)-1];
  logic cmd_v, is_cmd, is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst, start_wr, start_rd, unused_ok;
  assign cmd_v    = CKE & ~CS;
  assign is_cmd   = cmd_v & ~&{RAS, CAS, WE};
  assign is_act   = cmd_v & ({RAS, CAS, WE} == 3'b011);
  assign is_rd    = cmd_v & ({RAS, CAS, WE} == 3'b101);
  assign is_wr    = cmd_v & ({RAS, CAS, WE} == 3'b100);
  assign is_pre   = cmd_v & ({RAS, CAS, WE} == 3'b010);
  assign is_ref   = cmd_v & ({RAS, CAS, WE} == 3'b001);
  assign is_lmr   = cmd_v & ({RAS, CAS, WE} == 3'b000);
  assign is_bst   = cmd_v & ({RAS, CAS, WE} == 3'b110);
  assign bank     = BA[BANK_BITS-1:0];
  assign start_wr = is_wr & ready_q & open_q[bank];
  assign start_rd = is_rd & ready_q & open_q[bank];
  assign unused_ok = ^{BA, A};
  assign DQ_out   = out_q;
  assign DQ_oe    = oe_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign err_code = code_q;
  // Violation classification; the earliest-listed rule wins when several apply at once
  always_comb
    code = (~ready_q & (is_act | is_rd | is_wr | is_bst)) ? 3'd1 :
           (is_cmd & trfc_q != '0) ? 3'd5 :
           ((ready_q & (is_rd | is_wr) & ~open_q[bank]) | (is_ref & |open_q)) ? 3'd2 :
           (ready_q & (is_rd | is_wr) & trcd_q[bank] != '0) ? 3'd3 :
           (((ready_q & is_act) | is_ref) & trp_q != '0) ? 3'd4 :
           (ready_q & is_act & open_q[bank]) ? 3'd6 : 3'd0;
  // Mode register, bank rows, timing counters and first-error capture
  always_comb begin
    ready_d = ready_q | is_lmr;
    cl2_d   = is_lmr ? A[6:4] == 3'd2 : cl2_q;
    full_d  = is_lmr ? A[2:0] == 3'b111 : full_q;
    bl_d    = ~is_lmr ? bl_q : A[2:0] == 3'b001 ? 3'd1 : A[2:0] == 3'b010 ? 3'd3 : A[2:0] == 3'b011 ? 3'd7 : 3'd0;
    open_d  = open_q;
    row_d   = row_q;
    trcd_d  = trcd_q;
    trp_d   = trp_q;
    trfc_d  = trfc_q;
    if (CKE) begin
      for (int i = 0; i < NB; i++) trcd_d[i] = trcd_q[i] == '0 ? '0 : trcd_q[i] - 1'b1;
      trp_d  = trp_q == '0 ? '0 : trp_q - 1'b1;
      trfc_d = trfc_q == '0 ? '0 : trfc_q - 1'b1;
    end
    if (is_act & ready_q) begin
      open_d[bank] = 1'b1;
      row_d[bank]  = A[ROW_BITS-1:0];
      trcd_d[bank] = TW'(T_RCD - 1);
    end
    if (is_pre) begin
      if (A[10]) open_d = '0;
      else open_d[bank] = 1'b0;
      trp_d = TW'(T_RP - 1);
    end
    if (is_ref) trfc_d = TW'(T_RFC - 1);
    err_d  = err_q | (code != 3'd0);
    code_d = err_q ? code_q : code;
  end
  // Control state registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ready_q <= 1'b0;
      cl2_q   <= 1'b0;
      full_q  <= 1'b1;
      bl_q    <= '0;
      open_q  <= '0;
      row_q   <= '0;
      trcd_q  <= '0;
      trp_q   <= '0;
      trfc_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      ready_q <= ready_d;
      cl2_q   <= cl2_d;
      full_q  <= full_d;
      bl_q    <= bl_d;
      open_q  <= open_d;
      row_q   <= row_d;
      trcd_q  <= trcd_d;
      trp_q   <= trp_d;
      trfc_q  <= trfc_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  // Burst FSM state and burst context registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
      bb_q    <= '0;
      rb_q    <= '0;
      bfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      bb_q    <= bb_d;
      rb_q    <= rb_d;
      bfull_q <= bfull_d;
    end
  // Burst next state: a new READ/WRITE restarts, PRE/BST stops, otherwise advance one column per enabled cycle
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    bb_d    = bb_q;
    rb_d    = rb_q;
    bfull_d = bfull_q;
    if (start_wr | start_rd) begin
      state_d = (bl_q == '0 & ~full_q) ? IDLE : start_wr ? WBURST : RBURST;
      col_d   = A[COL_BITS-1:0] + 1'b1;
      cnt_d   = bl_q;
      bb_d    = bank;
      rb_d    = row_q[bank];
      bfull_d = full_q;
    end else if (is_pre | is_bst) state_d = IDLE;
    else if (CKE & state_q != IDLE) begin
      col_d = col_q + 1'b1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == 3'd1 & ~bfull_q) state_d = IDLE;
    end
  end
  // Burst outputs: the command beat uses the bus address, later beats the latched burst address
  always_comb begin
    we   = 1'b0;
    re   = 1'b0;
    addr = {bb_q, rb_q, col_q};
    if (start_wr | start_rd) begin
      addr = {bank, row_q[bank], A[COL_BITS-1:0]};
      we   = start_wr;
      re   = start_rd;
    end else if (CKE & ~is_pre & ~is_bst) begin
      we = state_q == WBURST;
      re = state_q == RBURST;
    end
  end
  // Backing RAM with byte-lane writes and a registered read port; contents survive reset
  always_ff @(posedge clk) begin
    if (we & ~DQML) mem[addr][7:0] <= DQ_in[7:0];
    if (we & ~DQMH) mem[addr][15:8] <= DQ_in[15:8];
    if (re) rd_q <= mem[addr];
  end
  // CAS-latency pipeline with a two-cycle DQM blanking path; everything freezes while CKE is low
  always_comb begin
    v_d   = CKE ? {v_q[1:0], re} : v_q;
    d_d   = CKE ? {d_q[0], rd_q} : d_q;
    m_d   = CKE ? {m_q[0], DQML | DQMH} : m_q;
    sel_v = cl2_q ? v_q[1] : v_q[2];
    sel_d = cl2_q ? d_q[0] : d_q[1];
    oe_d  = CKE ? sel_v & ~m_q[1] : oe_q;
    out_d = CKE ? ((sel_v & ~m_q[1]) ? sel_d : '0) : out_q;
  end
  // Read pipeline registers; async reset drops DQ_oe immediately
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v_q   <= '0;
      d_q   <= '0;
      m_q   <= '0;
      oe_q  <= 1'b0;
      out_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      m_q   <= m_d;
      oe_q  <= oe_d;
      out_q <= out_d;
    end
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb_sdram_cmd_responder: directed stimulus checked against a cycle-stamped behavioural SDRAM model
module tb_sdram_cmd_responder;
  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
  localparam logic [2:0] PRE = 3'b010, REF = 3'b001, LMR = 3'b000, BST = 3'b110;
  logic clk = 1'b0, reset = 1'b0, CKE = 1'b1, CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
  logic [2:0] BA = '0;
  logic [12:0] A = '0;
  logic DQML = 1'b0, DQMH = 1'b0;
  logic [15:0] DQ_in = '0, DQ_out;
  logic DQ_oe, ready, err;
  logic [2:0] err_code;
  int checks = 0, errors = 0;
  bit chk_on = 1'b0;

  sdram_cmd_responder dut (
    .clk(clk), .reset(reset), .CKE(CKE), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .BA(BA), .A(A), .DQML(DQML), .DQMH(DQMH), .DQ_in(DQ_in),
    .DQ_out(DQ_out), .DQ_oe(DQ_oe), .ready(ready), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Model state: timers are kept as the enabled-cycle stamp of the last ACT/PRE/REF
  bit m_ready, m_err;
  int m_cl, m_bl, m_code, last_pre, last_ref, ecyc;
  bit m_open [4];
  int m_row [4], last_act [4];
  int bk, b_bank, b_row, b_col, b_left;
  logic [15:0] mmem [int];
  bit exp_v [int], mask [int];
  logic [15:0] exp_d [int];
  logic e_oe, e_ready, e_err;
  logic [15:0] e_dq;
  logic [2:0] e_code;

  task automatic mreset();
    m_ready = 0; m_err = 0; m_code = 0; m_cl = 3; m_bl = 0;
    foreach (m_open[i]) begin m_open[i] = 0; m_row[i] = 0; last_act[i] = -1000; end
    last_pre = -1000; last_ref = -1000; ecyc = 0; bk = 0;
    exp_v.delete(); exp_d.delete(); mask.delete();
    e_oe = 0; e_dq = 0; e_ready = 0; e_err = 0; e_code = 0;
  endtask

  task automatic do_beat();
    int ad;
    logic [15:0] w;
    ad = (b_bank * 16 + b_row) * 256 + b_col;
    if (bk == 1) begin
      w = mmem.exists(ad) ? mmem[ad] : 16'h0;
      if (!DQML) w[7:0] = DQ_in[7:0];
      if (!DQMH) w[15:8] = DQ_in[15:8];
      mmem[ad] = w;
    end else begin
      exp_v[ecyc + m_cl] = 1;
      exp_d[ecyc + m_cl] = mmem.exists(ad) ? mmem[ad] : 16'hxxxx;
    end
    b_col = (b_col + 1) % 256;
    if (b_left > 0) begin
      b_left--;
      if (b_left == 0) bk = 0;
    end
  endtask

  task automatic step();
    int k, b, code;
    bit rw, any;
    k = CS ? 7 : int'({RAS, CAS, WE});
    b = int'(BA) % 4;
    rw = (k == 5 || k == 4);
    any = m_open[0] || m_open[1] || m_open[2] || m_open[3];
    code = 0;
    if (k != 7) begin
      if (!m_ready && (k == 3 || rw || k == 6)) code = 1;
      else if (ecyc - last_ref < 7) code = 5;
      else if ((rw && !m_open[b]) || (k == 1 && any)) code = 2;
      else if (rw && ecyc - last_act[b] < 2) code = 3;
      else if ((k == 3 || k == 1) && ecyc - last_pre < 2) code = 4;
      else if (k == 3 && m_open[b]) code = 6;
    end
    if (code != 1) begin
      if (k == 0) begin
        m_ready = 1;
        m_cl = (A[6:4] == 3'd2) ? 2 : 3;
        case (A[2:0]) 3'd1: m_bl = 2; 3'd2: m_bl = 4; 3'd3: m_bl = 8; 3'd7: m_bl = 0; default: m_bl = 1; endcase
      end else if (k == 3) begin m_open[b] = 1; m_row[b] = int'(A) % 16; last_act[b] = ecyc; end
      else if (k == 2) begin
        if (A[10]) foreach (m_open[i]) m_open[i] = 0;
        else m_open[b] = 0;
        last_pre = ecyc;
      end else if (k == 1) last_ref = ecyc;
    end
    if (rw && m_ready && m_open[b]) begin
      bk = (k == 4) ? 1 : 2; b_bank = b; b_row = m_row[b]; b_col = int'(A) % 256;
      b_left = (m_bl == 0) ? -1 : m_bl;
      do_beat();
    end else if (k == 2 || k == 6) bk = 0;
    else if (bk != 0) do_beat();
    if (code != 0 && !m_err) begin m_err = 1; m_code = code; end
    mask[ecyc] = DQML | DQMH;
    e_oe = exp_v.exists(ecyc) && !(mask.exists(ecyc - 2) && mask[ecyc - 2]);
    e_dq = e_oe ? exp_d[ecyc] : 16'h0;
    e_ready = m_ready; e_err = m_err; e_code = 3'(m_code);
    ecyc++;
  endtask

  // Model advances on every enabled edge and resets asynchronously like the device
  always @(posedge clk or negedge reset)
    if (!reset) mreset();
    else if (CKE) step();

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk)
    if (chk_on) begin
      chk("cyc_DQ_oe", 16'(DQ_oe), 16'(e_oe));
      chk("cyc_DQ_out", DQ_out, e_dq);
      chk("cyc_ready", 16'(ready), 16'(e_ready));
      chk("cyc_err", 16'(err), 16'(e_err));
      chk("cyc_err_code", 16'(err_code), 16'(e_code));
    end

  task automatic cyc(input logic [2:0] c, input int ba = 0, input int a = 0,
                     input logic [15:0] d = 16'h0, input logic ml = 1'b0, input logic mh = 1'b0);
    {RAS, CAS, WE} = c; CS = 1'b0; BA = 3'(ba); A = 13'(a); DQ_in = d; DQML = ml; DQMH = mh;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_DQ_oe", 16'(DQ_oe), 16'h0);
    chk("rst_DQ_out", DQ_out, 16'h0);
    chk("rst_ready", 16'(ready), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_err_code", 16'(err_code), 16'h0);
    reset = 1'b1;
    chk_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(REF);
      repeat (7) cyc(NOP);
    end
    chk("init_ready_before_lmr", 16'(ready), 16'h0);
    cyc(LMR, 0, 'h037);
    chk("lmr_ready", 16'(ready), 16'h1);
    chk("lmr_err", 16'(err), 16'h0);
    // full-page write of 12 beats, CL3
    cyc(ACT, 0, 5); cyc(NOP); cyc(NOP);
    cyc(WR, 0, 0, 16'h1000);
    for (int i = 1; i < 12; i++) cyc(NOP, 0, 0, 16'h1000 + 16'(i));
    cyc(PRE); cyc(NOP);
    cyc(ACT, 0, 5); cyc(NOP); cyc(NOP);
    cyc(RD, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      cyc(i == 12 ? PRE : NOP);
      if (i == 2) chk("fp_oe_before_cl", 16'(DQ_oe), 16'h0);
      if (i >= 3) chk("fp_rd_data", DQ_out, 16'h1000 + 16'(i - 3));
    end
    cyc(NOP);
    chk("fp_oe_after_pre", 16'(DQ_oe), 16'h0);
    // BL4 CL2 with page wrap
    cyc(LMR, 0, 'h022); cyc(NOP);
    cyc(ACT, 0, 5); cyc(NOP); cyc(NOP);
    cyc(WR, 0, 254, 16'hAAAA); cyc(NOP, 0, 0, 16'hBBBB); cyc(NOP, 0, 0, 16'hCCCC); cyc(NOP, 0, 0, 16'hDDDD);
    cyc(RD, 0, 254);
    cyc(NOP);
    chk("bl4_oe_t1", 16'(DQ_oe), 16'h0);
    cyc(NOP); chk("bl4_wrap_a", DQ_out, 16'hAAAA);
    cyc(NOP); chk("bl4_wrap_b", DQ_out, 16'hBBBB);
    cyc(NOP); chk("bl4_wrap_c", DQ_out, 16'hCCCC);
    cyc(NOP); chk("bl4_wrap_d", DQ_out, 16'hDDDD);
    cyc(NOP); chk("bl4_end_oe", 16'(DQ_oe), 16'h0);
    // byte masking on write and DQM blanking on read
    cyc(WR, 0, 10, 16'h1234); cyc(NOP, 0, 0, 16'h5678); cyc(NOP, 0, 0, 16'h9ABC); cyc(NOP, 0, 0, 16'hDEF0);
    cyc(WR, 0, 10, 16'hBEEF, 1'b0, 1'b1);
    cyc(BST, 0, 0, 16'hFFFF);
    cyc(RD, 0, 10);
    cyc(NOP, 0, 0, 16'h0, 1'b1, 1'b1);
    cyc(NOP); chk("mask_write", DQ_out, 16'h12EF);
    cyc(NOP); chk("mask_read_oe", 16'(DQ_oe), 16'h0);
    chk("mask_read_dq", DQ_out, 16'h0);
    cyc(NOP); chk("mask_beat3", DQ_out, 16'h9ABC);
    cyc(NOP); chk("mask_beat4", DQ_out, 16'hDEF0);
    cyc(NOP);
    // tRCD violation, then a later closed-bank violation must not overwrite it
    cyc(PRE, 0, 'h400); cyc(NOP);
    cyc(ACT, 0, 5);
    cyc(RD, 0, 10);
    chk("trcd_err", 16'(err), 16'h1);
    chk("trcd_code", 16'(err_code), 16'h3);
    cyc(RD, 1, 0);
    chk("closed_keeps_code", 16'(err_code), 16'h3);
    repeat (5) cyc(NOP);
    // asynchronous reset in the middle of a read burst
    cyc(RD, 0, 10); cyc(NOP); cyc(NOP);
    chk("pre_reset_oe", 16'(DQ_oe), 16'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_oe", 16'(DQ_oe), 16'h0);
    chk("async_rst_ready", 16'(ready), 16'h0);
    chk("async_rst_err", 16'(err), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(RD, 0, 0);
    chk("init_rd_err", 16'(err), 16'h1);
    chk("init_rd_code", 16'(err_code), 16'h1);
    repeat (3) cyc(NOP);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_responder.md
Name: sdram_cmd_responder

Overview:
- Synthesizable SDRAM device emulator: the target end of the memcon-style CKE/CS/RAS/CAS/WE/BA/A/DQM command bus.
- Decodes commands and tracks the mode register and per-bank open rows.
- Stores write bursts in an internal backing RAM and returns read bursts after CAS latency.
- Sits in simulation and FPGA loopback builds in place of the external SDRAM chip, and flags protocol or timing violations by the controller.

Parameters:
- BANK_BITS, 2, banks emulated (low bits of BA used).
- ROW_BITS, 4, row bits stored (low bits of A used; higher rows alias).
- COL_BITS, 8, column bits; full-page length = 2^COL_BITS.
- T_RCD, 2, min cycles ACT→READ/WRITE, same bank.
- T_RP, 2, min cycles PRE→ACT/REF.
- T_RFC, 7, min cycles REF→any non-NOP command.

Ports:
- clk  in  1  system clock, all sampling on rising edge.
- reset  in  1  asynchronous active-low reset.
- CKE  in  1  clock enable; low = every command ignored (treated as NOP).
- CS  in  1  chip select, active low.
- RAS  in  1  row strobe, active low.
- CAS  in  1  column strobe, active low.
- WE  in  1  write enable, active low.
- BA  in  3  bank address.
- A  in  13  address; A[10] = precharge-all on PRE.
- DQML  in  1  low-byte mask, active high.
- DQMH  in  1  high-byte mask, active high.
- DQ_in  in  16  write data from controller.
- DQ_out  out  16  read data.
- DQ_oe  out  1  high while DQ_out carries valid read data.
- ready  out  1  high once the first LOAD MODE is accepted.
- err  out  1  sticky violation flag; cleared only by reset.
- err_code  out  3  first violation: 1 cmd before LMR, 2 RD/WR to closed bank, 3 tRCD, 4 tRP, 5 tRFC, 6 ACT to open bank.

Behaviour:
- Reset: DQ_out=0, DQ_oe=0, ready=0, err=0, err_code=0.
  - Also: all banks closed, mode register = CL3 full-page, burst FSM IDLE, timers 0.
  - Backing RAM contents are not reset.
- Decode: command is valid only when CKE=1 and CS=0. {RAS,CAS,WE}:
  - 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 LMR, 110 BURST-STOP.
- Init phase (ready=0):
  - Only NOP/PRE/REF/LMR are legal; any other command sets err, code 1, and is ignored.
  - LMR latches A[6:4] as CL (2 or 3; other values → 3) and A[2:0] as BL (000=1, 001=2, 010=4, 011=8, 111=full page, others=1).
  - ready rises the cycle after LMR.
  - LMR after ready is accepted and updates the mode register.
- ACT: opens bank BA, latches row A[ROW_BITS-1:0], starts the bank tRCD counter. ACT to an already-open bank: err code 6; row is still updated.
- PRE: closes bank BA, or all banks if A[10]=1. Starts the tRP counter.
- REF: legal only with all banks closed (else code 2). Starts the tRFC counter.
- A command issued before its timer expires sets the matching err code but is still executed.
- Error capture: err_code holds the first violation; later violations leave it unchanged.
- Burst FSM states IDLE, WBURST, RBURST. Address = {BA, open row, col}; col = A[COL_BITS-1:0] at the command.
- WRITE:
  - Writes DQ_in in the same cycle as the command (write latency 0).
  - Then one beat per cycle, col+1 each beat, wrapping within the page.
  - Total BL beats, or unlimited for full page.
  - Byte lanes are masked by DQML/DQMH sampled in the same cycle.
- READ:
  - RAM read issued at the command, col+1 per cycle, same BL rules.
  - Data is presented on DQ_out with DQ_oe=1 exactly CL cycles after each beat's issue cycle. A READ at cycle t gives its first word at t+CL.
  - DQM sampled at an issue cycle blanks that beat at output (DQ_oe=0, DQ_out=0) 2 cycles later.
- Burst interaction:
  - A new READ/WRITE during a burst terminates the old burst and starts the new one in that cycle.
  - PRE or BURST-STOP during a write: no write that cycle, FSM → IDLE.
  - PRE or BURST-STOP during a read: stops new issues; already-issued beats still drain through the CL pipeline.
- Write→read turnaround: WRITE data already written is visible to a READ issued the next cycle.
- CKE=0 mid-burst: bursts freeze (no issue, no column advance). Pipeline and timers also hold.
- Reset asserted mid-burst: immediate return to reset state; DQ_oe drops asynchronously.

Test Plan:
- Init: reset, 8×REF, then LMR with A=0x037 → ready=1 next cycle, CL=3, full page, err=0.
- Full-page write/read:
  - ACT bank0 row 5, wait 3, WRITE col 0.
  - Drive DQ_in=0x1000+i for 12 beats, then PRE.
  - ACT, READ col 0 at cycle t → DQ_oe rises at t+3, DQ_out=0x1000..0x100B, then PRE stops issue.
- BL=4, CL=2 via LMR A=0x022:
  - WRITE col 254 with data A..D → stored at cols 254, 255, 0, 1 (page wrap).
  - READ col 254 → A,B,C,D from t+2.
- Masking: write beat with DQMH=1, DQML=0, data 0xBEEF over 0x1234 → read back 0x12EF; read beat with DQM=1 → DQ_oe low 2 cycles later.
- Violations:
  - READ 1 cycle after ACT → err=1, code 3.
  - Then READ to closed bank 1 → err_code stays 3.
- Reset mid read burst → DQ_oe=0 immediately, ready=0, and READ before LMR sets code 1.
